btn_conditioner: RTL and testbench

- Conditions the raw board pushbutton before the clock-divider/CPU reset path.
- Synchronises the asynchronous button into the board clock domain and debounces it.
- Produces single-cycle press/release strobes.
- Drives a stretched, active-high synchronous reset for the CPU core: power-on pulse, plus hold-while-pressed, plus a post-release tail.

---
 rtl/btn_conditioner.sv | 80 ++++++++
 tb/tb_btn_conditioner.sv | 128 ++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and edge-detect a raw pushbutton and stretch a CPU reset from it
// Ports:
//   clk         board clock, all logic on the rising edge
//   reset       synchronous active-low reset
//   btn_in      raw asynchronous, bouncing button
//   btn_level   debounced button level
//   btn_press   one-cycle strobe on an accepted 0->1
//   btn_release one-cycle strobe on an accepted 1->0
//   cpu_reset   active-high reset for the CPU core: power-on pulse, held while pressed, tail after release
module btn_conditioner #(
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int RST_PULSE_CYCLES = 16,
    parameter int CNT_W            = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic cpu_reset
);
    localparam int RW = $clog2(RST_PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RST_LD = RW'(RST_PULSE_CYCLES);
    typedef enum logic [1:0] {IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW} state_t;
    state_t state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RW-1:0] rst_cnt_q;
    logic level_q, press_q, release_q;
    logic s;
    // only the last synchroniser stage is safe to use; the first may go metastable
    assign s = sync_q[SYNC_STAGES-1];
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q    <= '0;
            state_q   <= IDLE_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rst_cnt_q <= RST_LD;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_in};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            // reload while the button is held so the tail starts counting from the release edge
            rst_cnt_q <= level_q ? RST_LD : (rst_cnt_q != '0 ? rst_cnt_q - RW'(1) : '0);
            case (state_q)
                IDLE_LOW: if (s) begin
                    state_q <= CHECK_HIGH;
                    cnt_q   <= '0;
                end
                CHECK_HIGH: if (!s) state_q <= IDLE_LOW;
                else if (cnt_q == CNT_TC) begin
                    state_q <= IDLE_HIGH;
                    level_q <= 1'b1;
                    press_q <= 1'b1;
                end else cnt_q <= cnt_q + CNT_W'(1);
                IDLE_HIGH: if (!s) begin
                    state_q <= CHECK_LOW;
                    cnt_q   <= '0;
                end
                CHECK_LOW: if (s) state_q <= IDLE_HIGH;
                else if (cnt_q == CNT_TC) begin
                    state_q   <= IDLE_LOW;
                    level_q   <= 1'b0;
                    release_q <= 1'b1;
                end else cnt_q <= cnt_q + CNT_W'(1);
                default: state_q <= IDLE_LOW;
            endcase
        end
    end
    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign cpu_reset   = level_q | (rst_cnt_q != '0);
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed and random checks of btn_conditioner against a run-length reference model
module tb_btn_conditioner;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int PUL  = 3;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_in = 1'b0;
    logic btn_level, btn_press, btn_release, cpu_reset;
    int n_tests = 0;
    int n_fail = 0;
    btn_conditioner #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .RST_PULSE_CYCLES(PUL), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release), .cpu_reset(cpu_reset)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    // Reference: s is btn_in seen SYNC edges late; the level flips once s has
    // disagreed with it on DEB+1 consecutive edges; the reset tail reloads while pressed.
    bit hist[$];
    int run = 0;
    int m_rc = PUL;
    bit m_lvl = 0, m_press = 0, m_rel = 0, go = 0;
    always @(posedge clk) begin
        bit s;
        go = 1;
        if (!reset) begin
            hist.delete();
            run = 0; m_lvl = 0; m_press = 0; m_rel = 0; m_rc = PUL;
        end else begin
            s = (hist.size() == SYNC) ? hist[0] : 1'b0;
            hist.push_back(btn_in);
            if (hist.size() > SYNC) void'(hist.pop_front());
            m_rc = m_lvl ? PUL : (m_rc > 0 ? m_rc - 1 : 0);
            m_press = 0; m_rel = 0;
            if (s != m_lvl) begin
                run++;
                if (run == DEB + 1) begin
                    m_lvl = !m_lvl; m_press = m_lvl; m_rel = !m_lvl; run = 0;
                end
            end else run = 0;
        end
    end
    always @(negedge clk) if (go) begin
        chk("level", int'(btn_level), int'(m_lvl));
        chk("press", int'(btn_press), int'(m_press));
        chk("release", int'(btn_release), int'(m_rel));
        chk("cpu_reset", int'(cpu_reset), int'(m_lvl || m_rc != 0));
        chk("press_and_release", int'(btn_press & btn_release), 0);
    end
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    // counts edges until the selected event is visible, bounded
    task automatic edges_to(input int which, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(which == 0 ? btn_press : which == 1 ? btn_release : !cpu_reset) && n < 40);
    endtask
    initial begin
        int n;
        cyc(2);
        chk("por_cpu_reset", int'(cpu_reset), 1);
        chk("por_level", int'(btn_level), 0);
        reset = 1'b1;
        edges_to(2, n);
        chk("por_tail", n, PUL);
        cyc(4);
        btn_in = 1'b1;
        edges_to(0, n);
        chk("press_latency", n - 1, SYNC + DEB);
        cyc(5);
        chk("held_cpu_reset", int'(cpu_reset), 1);
        btn_in = 1'b0;
        edges_to(1, n);
        chk("release_latency", n - 1, SYNC + DEB);
        edges_to(2, n);
        chk("release_tail", n, PUL);
        for (int i = 0; i < 5; i++) begin
            btn_in = 1'b1; cyc(3);
            btn_in = 1'b0; cyc(1);
        end
        cyc(6);
        chk("bounce_level", int'(btn_level), 0);
        btn_in = 1'b1;
        edges_to(0, n);
        chk("bounce_then_press", n - 1, SYNC + DEB);
        cyc(3);
        btn_in = 1'b0; cyc(3);
        btn_in = 1'b1; cyc(10);
        chk("release_bounce_level", int'(btn_level), 1);
        btn_in = 1'b0; cyc(12);
        chk("idle_low_level", int'(btn_level), 0);
        btn_in = 1'b1; cyc(5);
        reset = 1'b0; cyc(1);
        chk("mid_reset_level", int'(btn_level), 0);
        chk("mid_reset_cpu_reset", int'(cpu_reset), 1);
        reset = 1'b1;
        edges_to(0, n);
        chk("requalify_latency", n - 1, SYNC + DEB);
        cyc(3);
        for (int i = 0; i < 300; i++) begin
            bit v;
            int len;
            v = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            repeat (len) begin
                @(negedge clk);
                btn_in = v;
                reset = ($urandom_range(0, 150) != 0);
            end
        end
        reset = 1'b1;
        cyc(20);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
